// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 size codes,
// controller state encoding and small access-classification helpers.
package mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ACCESS2 = 2'd2,
        RESPOND = 2'd3
    } lsu_state_t;

    // Loads accept signed/unsigned byte and half plus word; stores only the
    // signed size codes, since sign has no meaning for a write.
    function automatic logic is_illegal(input logic we, input logic [2:0] func3);
        if (we) begin
            return func3[2] || (func3[1:0] == 2'b11);
        end
        return (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
    endfunction

    // An access is misaligned when it spills past the end of its word.
    // A half at offset 1 still fits in bytes 1..2 and is fine.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        return ((func3[1:0] == 2'b01) && (off == 2'd3)) ||
               ((func3[1:0] == 2'b10) && (off != 2'd0));
    endfunction

    // Byte-enable pattern of an access before it is shifted to its lane.
    function automatic logic [3:0] base_mask(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the addressed bytes out of a 64-bit read window
// (high word only meaningful for split accesses), then sign- or
// zero-extends them according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = 32'(window >> {offset, 3'b000});

    // Mask to access size and extend to a full register word.
    always_comb begin
        rdata = shifted;
        case (func3)
            MEM_B:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            MEM_H:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            MEM_BU:  rdata = {24'h0, shifted[7:0]};
            MEM_HU:  rdata = {16'h0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed front end to a word-wide synchronous RAM.
// Accepts one request in IDLE, performs one (or, for a split misaligned
// access, two) word cycles, and returns a single-cycle response.
// Build option: MISALIGNED_SPLIT_EN -- when defined, misaligned accesses are
// carried out as two word accesses; otherwise they are rejected with rsp_err.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_func3,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_wen,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            func3_q;
    logic [31:0]           wdata_q;
    logic                  err_q;

    logic                  req_reject;
    logic [1:0]            off;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic [3:0]            strb_lo;
    logic [31:0]           wdata_lo;
    logic [63:0]           rd_window;
    logic [31:0]           load_word;

`ifdef MISALIGNED_SPLIT_EN
    logic                  split_q;
    logic [31:0]           held_q;
    logic [3:0]            strb_hi;
    logic [31:0]           wdata_hi;

    // Misaligned requests are legal here; only a bad funct3 is refused.
    assign req_reject = is_illegal(req_we, req_func3);
    assign {strb_hi, strb_lo}   = {4'h0, base_mask(func3_q)} << off;
    assign {wdata_hi, wdata_lo} = {32'h0, wdata_q} << {off, 3'b000};
    assign rd_window = split_q ? {mem_rdata, held_q} : {32'h0, mem_rdata};
`else
    assign req_reject = is_illegal(req_we, req_func3) ||
                        is_misaligned(req_func3, req_addr[1:0]);
    assign strb_lo   = base_mask(func3_q) << off;
    assign wdata_lo  = wdata_q << {off, 3'b000};
    assign rd_window = {32'h0, mem_rdata};
`endif

    assign off       = addr_q[1:0];
    assign word_addr = addr_q[ADDR_WIDTH-1:2];

    load_align u_load_align (
        .window (rd_window),
        .offset (off),
        .func3  (func3_q),
        .rdata  (load_word)
    );

    // State register plus the request captured at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            func3_q <= 3'b000;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            split_q <= 1'b0;
            held_q  <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                func3_q <= req_func3;
                wdata_q <= req_wdata;
                err_q   <= req_reject;
`ifdef MISALIGNED_SPLIT_EN
                split_q <= is_misaligned(req_func3, req_addr[1:0]);
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            // Low word of a split read arrives while the high word is addressed.
            if (state_q == ACCESS2) begin
                held_q <= mem_rdata;
            end
`endif
        end
    end

    // Next-state and output decode; reset forces every output quiet.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_reject ? RESPOND : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = word_addr;
                if (we_q) begin
                    mem_wen   = 1'b1;
                    mem_wstrb = strb_lo;
                    mem_wdata = wdata_lo;
                end
`ifdef MISALIGNED_SPLIT_EN
                state_d = split_q ? ACCESS2 : RESPOND;
`else
                state_d = RESPOND;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            ACCESS2: begin
                mem_addr = word_addr + 1'b1;
                if (we_q) begin
                    mem_wen   = 1'b1;
                    mem_wstrb = strb_hi;
                    mem_wdata = wdata_hi;
                end
                state_d = RESPOND;
            end
`endif
            RESPOND: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'h0 : load_word;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d   = IDLE;
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = 32'h0;
            rsp_err   = 1'b0;
            mem_addr  = '0;
            mem_wen   = 1'b0;
            mem_wstrb = 4'h0;
            mem_wdata = 32'h0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array shadow memory predicts every
// response and every RAM write; a per-cycle compare process checks the DUT.
module tb_load_store_unit;
    import mem_pkg::*;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [29:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_func3 (req_func3),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM environment (16 words), preloaded during the first reset.
    logic [31:0] ram [16];
    logic        preload;
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr[3:0]];
        if (preload) begin
            for (int w = 0; w < 16; w++) ram[w] <= 32'h0;
            ram[0] <= 32'h4433_2211;
            ram[1] <= 32'h8077_66F0;
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [7:0]  sh [64];
    int          cyc = 0;
    int          tx_c0 = -10, tx_end = -10;
    logic [31:0] e_rdata;
    logic        e_err;
    int          nw = 0;
    int          w_cyc  [2];
    logic [29:0] w_addr [2];
    logic [3:0]  w_strb [2];
    logic [31:0] w_data [2];
    bit          got_rsp;
    logic [31:0] last_rdata;
    int          errors = 0, checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sh_word(input int w);
        return {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]};
    endfunction

    // Per-cycle comparison against the model's expectations.
    always @(negedge clk) begin : compare
        int wi;
        if (reset) begin
            chk("rst_ready", {31'h0, req_ready}, 32'h0);
            chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
            chk("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
            chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
            chk("rst_mem_addr", {2'b00, mem_addr}, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end else begin
            chk("ready", {31'h0, req_ready}, {31'h0, !(cyc > tx_c0 && cyc <= tx_end)});
            if (cyc == tx_end) begin
                chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
                got_rsp    = 1'b1;
                last_rdata = rsp_rdata;
            end else begin
                chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
                chk("idle_rsp_rdata", rsp_rdata, 32'h0);
                chk("idle_rsp_err", {31'h0, rsp_err}, 32'h0);
            end
            wi = -1;
            for (int i = 0; i < nw; i++) if (w_cyc[i] == cyc) wi = i;
            if (wi >= 0) begin
                chk("wr_wen", {31'h0, mem_wen}, 32'h1);
                chk("wr_addr", {2'b00, mem_addr}, {2'b00, w_addr[wi]});
                chk("wr_strb", {28'h0, mem_wstrb}, {28'h0, w_strb[wi]});
                chk("wr_data", mem_wdata, w_data[wi]);
            end else begin
                chk("no_wen", {31'h0, mem_wen}, 32'h0);
            end
        end
    end

    // Byte-level model: what a load returns / which bytes a store changes.
    task automatic model(input logic we, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output int lat);
        int size, off, ba, k, lane;
        bit legal, mis, err;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 == MEM_B || f3 == MEM_H || f3 == MEM_W)
                   : (f3 == MEM_B || f3 == MEM_H || f3 == MEM_W || f3 == MEM_BU || f3 == MEM_HU);
        off   = int'(a[1:0]);
        mis   = (size == 2 && off == 3) || (size == 4 && off != 0);
        err   = !legal || (mis && !SPLIT);
        e_err = err;
        e_rdata = 32'h0;
        nw = 0;
        if (err) begin
            lat = 1;
        end else begin
            lat = mis ? 3 : 2;
            if (we) begin
                nw = mis ? 2 : 1;
                for (int j = 0; j < 2; j++) begin
                    w_strb[j] = 4'h0;
                    w_data[j] = 32'h0;
                    w_addr[j] = a[31:2] + 30'(j);
                end
                for (int i = 0; i < size; i++) begin
                    ba   = int'(a) + i;
                    k    = ((ba >> 2) != int'(a >> 2)) ? 1 : 0;
                    lane = ba % 4;
                    w_strb[k][lane] = 1'b1;
                    w_data[k][8*lane +: 8] = wd[8*i +: 8];
                    sh[ba % 64] = wd[8*i +: 8];
                end
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = sh[(int'(a) + i) % 64];
                if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
                e_rdata = v;
            end
        end
    endtask

    task automatic txn(input string name, input logic we, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input bit lit_en, input logic [31:0] lit);
        int lat, w;
        @(posedge clk); #1;
        model(we, a, f3, wd, lat);
        for (int k = 0; k < nw; k++) w_cyc[k] = cyc + 1 + k;
        got_rsp   = 1'b0;
        tx_c0     = cyc;
        tx_end    = cyc + lat;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_func3 = f3;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_func3 = 3'b000;
        req_wdata = 32'h0;
        repeat (lat) @(posedge clk);
        #1;
        chk({name, "_seen"}, {31'h0, got_rsp}, 32'h1);
        if (lit_en) begin
            chk({name, "_model"}, e_rdata, lit);
            chk({name, "_dut"}, last_rdata, lit);
        end
        for (int k = 0; k < 2; k++) begin
            w = (int'(a >> 2) + k) % 16;
            chk({name, "_ram"}, ram[w], sh_word(w));
        end
        $display("txn %-10s we=%0d addr=%h f3=%b wdata=%h -> rdata=%h err=%0d lat=%0d",
                 name, we, a, f3, wd, last_rdata, e_err, lat);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) sh[i] = 8'h0;
        {sh[3], sh[2], sh[1], sh[0]} = 32'h4433_2211;
        {sh[7], sh[6], sh[5], sh[4]} = 32'h8077_66F0;
        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_func3 = 3'b000; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; preload = 1'b0;

        txn("lb5",   1'b0, 32'h5, MEM_B,  32'h0, 1'b1, 32'h0000_0066);
        txn("lb4",   1'b0, 32'h4, MEM_B,  32'h0, 1'b1, 32'hFFFF_FFF0);
        txn("lbu4",  1'b0, 32'h4, MEM_BU, 32'h0, 1'b1, 32'h0000_00F0);
        txn("sh6",   1'b1, 32'h6, MEM_H,  32'h1234_ABCD, 1'b0, 32'h0);
        txn("lw4a",  1'b0, 32'h4, MEM_W,  32'h0, 1'b1, 32'hABCD_66F0);
        txn("sw4",   1'b1, 32'h4, MEM_W,  32'h8877_6655, 1'b0, 32'h0);
        txn("lw3",   1'b0, 32'h3, MEM_W,  32'h0, 1'b1, SPLIT ? 32'h7766_5544 : 32'h0);
        txn("sw6",   1'b1, 32'h6, MEM_W,  32'hDEAD_BEEF, 1'b0, 32'h0);
        txn("lw4b",  1'b0, 32'h4, MEM_W,  32'h0, 1'b1, SPLIT ? 32'hBEEF_6655 : 32'h8877_6655);
        txn("lw8",   1'b0, 32'h8, MEM_W,  32'h0, 1'b1, SPLIT ? 32'h0000_DEAD : 32'h0);
        txn("lh5",   1'b0, 32'h5, MEM_H,  32'h0, 1'b1, SPLIT ? 32'hFFFF_EF66 : 32'h0000_7766);
        txn("lhu2",  1'b0, 32'h2, MEM_HU, 32'h0, 1'b1, 32'h0000_4433);
        txn("lh7",   1'b0, 32'h7, MEM_H,  32'h0, 1'b1, SPLIT ? 32'hFFFF_ADBE : 32'h0);
        txn("ld011", 1'b0, 32'h0, 3'b011, 32'h0, 1'b1, 32'h0);
        txn("st100", 1'b1, 32'h0, 3'b100, 32'h5555_5555, 1'b0, 32'h0);
        txn("ld111", 1'b0, 32'h4, 3'b111, 32'h0, 1'b1, 32'h0);
        txn("st101", 1'b1, 32'h4, 3'b101, 32'h6666_6666, 1'b0, 32'h0);

        // Reset during the ACCESS cycle of SW 0x0: no write, no response.
        @(posedge clk); #1;
        nw = 0; tx_c0 = cyc; tx_end = -10;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
        req_func3 = MEM_W; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'h0; req_func3 = 3'b000;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_ram", ram[0], 32'h4433_2211);
        $display("txn abort      we=1 addr=00000000 -> ram0=%h", ram[0]);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
